// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multiport register file.
// Pure declarations: no logic, no latency.
package regfile_pkg;

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam int XLEN_DEF    = 32;
    localparam int NREGS_DEF   = 32;
    localparam int NRD_DEF     = 2;
    localparam int SP_IDX_DEF  = 2;
    localparam int SP_INIT_DEF = 64;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read path: array mux, x0 forced to zero, optional write bypass.
// Zero latency, no backpressure; output held at 0 until the file is ready.
module regfile_read_port #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic [XLEN-1:0] regs [NREGS],
    input  logic [AW-1:0]   sel,
    input  logic            ready,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_idx,
    input  logic [XLEN-1:0] wr_data,
    output logic [XLEN-1:0] data
);

    // sel != 0 together with wr_idx == sel already excludes writes to x0.
    always_comb begin
        data = '0;
        if (ready && sel != '0) begin
            if (wr_en && wr_idx == sel) begin
                data = wr_data;
            end else begin
                data = regs[sel];
            end
        end
    end

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised register file: init sweep, NRD bypassed read ports, pending scoreboard, two debug taps.
// Reads are zero latency; writes land on the next rising edge; nothing stalls once ready.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int NREGS   = NREGS_DEF,
    parameter int AW      = $clog2(NREGS),
    parameter int NRD     = NRD_DEF,
    parameter int SP_IDX  = SP_IDX_DEF,
    parameter int SP_INIT = SP_INIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              regWrite,
    input  logic [AW-1:0]     rd,
    input  logic [XLEN-1:0]   writeData,
    input  logic [NRD*AW-1:0] rs,
    output logic [NRD*XLEN-1:0] readData,
    output logic [NRD-1:0]    rsPending,
    input  logic              markValid,
    input  logic [AW-1:0]     markRd,
    output logic              ready,
    input  logic [AW-1:0]     displaySelect,
    output logic [XLEN-1:0]   displayData,
    input  logic [AW-1:0]     vgaSelect,
    output logic [XLEN-1:0]   vgaData
);

    state_t            state;
    logic [AW-1:0]     idx;
    logic [XLEN-1:0]   regs [NREGS];
    logic [NREGS-1:0]  pending;
    logic              wr_en;

    assign ready = (state == S_RUN);
    assign wr_en = ready && regWrite && (rd != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_INIT;
            idx   <= AW'(1);
        end else if (state == S_INIT) begin
            idx <= idx + 1'b1;
            if (idx == AW'(NREGS - 1)) begin
                state <= S_RUN;
            end
        end
    end

    // Array has no reset so it can map onto RAM/LUT storage; the sweep initialises it.
    always_ff @(posedge clk) begin
        if (state == S_INIT) begin
            regs[idx] <= (idx == AW'(SP_IDX)) ? XLEN'(SP_INIT) : '0;
        end else if (wr_en) begin
            regs[rd] <= writeData;
        end
    end

    // Set is applied after clear so a newer producer wins over a retiring one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else if (ready) begin
            if (wr_en) begin
                pending[rd] <= 1'b0;
            end
            if (markValid && markRd != '0) begin
                pending[markRd] <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        regfile_read_port #(
            .XLEN  (XLEN),
            .NREGS (NREGS),
            .AW    (AW)
        ) u_port (
            .regs    (regs),
            .sel     (rs[k*AW +: AW]),
            .ready   (ready),
            .wr_en   (wr_en),
            .wr_idx  (rd),
            .wr_data (writeData),
            .data    (readData[k*XLEN +: XLEN])
        );

        assign rsPending[k] = ready & pending[rs[k*AW +: AW]];
    end

    // Debug taps see the array only, so a write shows up one cycle later.
    regfile_read_port #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .AW    (AW)
    ) u_display (
        .regs    (regs),
        .sel     (displaySelect),
        .ready   (ready),
        .wr_en   (1'b0),
        .wr_idx  ('0),
        .wr_data ('0),
        .data    (displayData)
    );

    regfile_read_port #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .AW    (AW)
    ) u_vga (
        .regs    (regs),
        .sel     (vgaSelect),
        .ready   (ready),
        .wr_en   (1'b0),
        .wr_idx  ('0),
        .wr_data ('0),
        .data    (vgaData)
    );

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport with hand-computed expectations.
module tb_regfile_multiport;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int NRD   = 2;

    logic                 clk;
    logic                 rst_n;
    logic                 regWrite;
    logic [AW-1:0]        rd;
    logic [XLEN-1:0]      writeData;
    logic [NRD*AW-1:0]    rs;
    logic [NRD*XLEN-1:0]  readData;
    logic [NRD-1:0]       rsPending;
    logic                 markValid;
    logic [AW-1:0]        markRd;
    logic                 ready;
    logic [AW-1:0]        displaySelect;
    logic [XLEN-1:0]      displayData;
    logic [AW-1:0]        vgaSelect;
    logic [XLEN-1:0]      vgaData;

    int checks   = 0;
    int failures = 0;
    int n_cyc;

    regfile_multiport #(
        .XLEN    (XLEN),
        .NREGS   (NREGS),
        .AW      (AW),
        .NRD     (NRD),
        .SP_IDX  (2),
        .SP_INIT (64)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .regWrite      (regWrite),
        .rd            (rd),
        .writeData     (writeData),
        .rs            (rs),
        .readData      (readData),
        .rsPending     (rsPending),
        .markValid     (markValid),
        .markRd        (markRd),
        .ready         (ready),
        .displaySelect (displaySelect),
        .displayData   (displayData),
        .vgaSelect     (vgaSelect),
        .vgaData       (vgaData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge, well clear of it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rs(input logic [AW-1:0] r0, input logic [AW-1:0] r1);
        rs = {r1, r0};
    endtask

    // Counts rising edges from release until ready; stray init-time stimulus is dropped at edge 10.
    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 100) begin
            tick();
            n++;
            if (n == 10) begin
                regWrite  = 1'b0;
                markValid = 1'b0;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; regWrite = 1'b0; rd = '0; writeData = '0;
        markValid = 1'b0; markRd = '0; displaySelect = '0; vgaSelect = '0;
        set_rs(5'd2, 5'd5);
        repeat (3) tick();
        #1;
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_pending", {30'd0, rsPending}, 32'd0);
        chk("rst_rd0", readData[31:0], 32'd0);

        // Write and mark during the sweep must both be ignored.
        regWrite = 1'b1; rd = 5'd3; writeData = 32'd5;
        markValid = 1'b1; markRd = 5'd3;
        tick();
        rst_n = 1'b1;
        wait_ready(n_cyc);
        // Ready holds in cycle 32 counting the release cycle as cycle 1, i.e. after 31 edges.
        chk("init_len", n_cyc, 32'd31);

        set_rs(5'd2, 5'd5); vgaSelect = 5'd2; displaySelect = 5'd3;
        #1;
        chk("init_sp", readData[31:0], 32'd64);
        chk("init_r5", readData[63:32], 32'd0);
        chk("init_vga_sp", vgaData, 32'd64);
        chk("notready_wr_r3", displayData, 32'd0);
        set_rs(5'd3, 5'd5);
        #1;
        chk("notready_mark_r3", {30'd0, rsPending}, 32'd0);

        tick();
        regWrite = 1'b1; rd = 5'd7; writeData = 32'hDEADBEEF;
        set_rs(5'd7, 5'd0); displaySelect = 5'd7;
        #1;
        chk("bypass_rd0", readData[31:0], 32'hDEADBEEF);
        chk("tap_before", displayData, 32'd0);
        tick();
        regWrite = 1'b0;
        #1;
        chk("tap_after", displayData, 32'hDEADBEEF);
        chk("stored_rd0", readData[31:0], 32'hDEADBEEF);

        regWrite = 1'b1; rd = 5'd0; writeData = 32'h1234;
        #1;
        chk("x0_same", readData[63:32], 32'd0);
        tick();
        regWrite = 1'b0; markValid = 1'b1; markRd = 5'd0;
        #1;
        chk("x0_later", readData[63:32], 32'd0);
        tick();
        markValid = 1'b0;
        #1;
        chk("x0_pending", {30'd0, rsPending}, 32'd0);

        set_rs(5'd9, 5'd9); markValid = 1'b1; markRd = 5'd9;
        #1;
        chk("mark_not_yet", {30'd0, rsPending}, 32'd0);
        tick();
        markValid = 1'b0;
        #1;
        chk("mark_set", {30'd0, rsPending}, 32'd3);
        regWrite = 1'b1; rd = 5'd9; writeData = 32'h99;
        #1;
        chk("clear_no_bypass", {30'd0, rsPending}, 32'd3);
        chk("clear_data_bypass", readData[31:0], 32'h99);
        tick();
        regWrite = 1'b0;
        #1;
        chk("clear_done", {30'd0, rsPending}, 32'd0);
        regWrite = 1'b1; rd = 5'd9; writeData = 32'h100;
        markValid = 1'b1; markRd = 5'd9;
        tick();
        regWrite = 1'b0; markValid = 1'b0;
        #1;
        chk("set_wins", {30'd0, rsPending}, 32'd3);

        regWrite = 1'b1; rd = 5'd4; writeData = 32'hAA;
        tick();
        regWrite = 1'b0; markValid = 1'b1; markRd = 5'd4;
        tick();
        markValid = 1'b0; set_rs(5'd4, 5'd2); vgaSelect = 5'd7;
        #1;
        chk("pre_rst_r4", readData[31:0], 32'hAA);
        chk("pre_rst_pend", {30'd0, rsPending}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_pend", {30'd0, rsPending}, 32'd0);
        chk("mid_rst_ready", {31'd0, ready}, 32'd0);
        tick();
        rst_n = 1'b1;
        wait_ready(n_cyc);
        chk("reinit_len", n_cyc, 32'd31);
        #1;
        chk("reinit_r4", readData[31:0], 32'd0);
        chk("reinit_sp", readData[63:32], 32'd64);
        chk("reinit_r7_vga", vgaData, 32'd0);
        chk("reinit_pend", {30'd0, rsPending}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
